// File: rtl/dma_tx_burst_sched.sv
// Round-robin burst scheduler: steers one upstream DMA stream to one of N_DST loaders,
// one burst of burst_len beats per grant, TLAST on the final beat.
module dma_tx_burst_sched #(
  parameter int unsigned N_DST = 8,
  parameter int unsigned DW    = 64,
  parameter int unsigned LW    = 16,
  localparam int unsigned IW   = $clog2(N_DST)
) (
  input  logic             clk_dma,
  input  logic             srst,
  input  logic [LW-1:0]    burst_len,
  input  logic             s_axi_dma_tvld,
  output logic             s_axi_dma_trdy,
  input  logic [DW-1:0]    s_axi_dma_tdat,
  input  logic [N_DST-1:0] dst_req,
  output logic [N_DST-1:0] m_axi_tvld,
  input  logic [N_DST-1:0] m_axi_trdy,
  output logic [DW-1:0]    m_axi_tdat,
  output logic             m_axi_tlast,
  output logic             grant_vld,
  output logic [IW-1:0]    grant_idx,
  output logic             burst_done,
  output logic [31:0]      burst_total
);

  typedef enum logic {StArb = 1'b0, StXfer = 1'b1} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [IW-1:0]   r_rr_ptr;
  logic [IW-1:0]   r_grant_idx;
  logic [LW-1:0]   r_len;
  logic [LW-1:0]   r_beat_cnt;
  logic            r_burst_done;
  logic [31:0]     r_burst_total;

  logic            w_pick_found;
  logic [IW-1:0]   w_pick_idx;
  logic            w_beat;
  logic            w_last;
  logic [IW-1:0]   w_rr_next;

  // First requester at or after the round-robin pointer, wrapping modulo N_DST.
  always_comb begin
    int unsigned v_cand;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    v_cand       = 0;
    for (int unsigned i = 0; i < N_DST; i++) begin
      v_cand = (32'(r_rr_ptr) + i) % N_DST;
      if (!w_pick_found && dst_req[v_cand[IW-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = v_cand[IW-1:0];
      end
    end
  end

  assign w_last    = (r_beat_cnt == r_len - LW'(1));
  assign w_beat    = (r_state == StXfer) && s_axi_dma_tvld && m_axi_trdy[r_grant_idx];
  assign w_rr_next = (r_grant_idx == IW'(N_DST - 1)) ? '0 : r_grant_idx + IW'(1);

  always_ff @(posedge clk_dma) begin
    if (srst) begin
      r_state <= StArb;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    s_axi_dma_trdy = 1'b0;
    m_axi_tvld     = '0;
    m_axi_tlast    = 1'b0;
    case (r_state)
      StArb: begin
        if (w_pick_found) begin
          w_state_d = StXfer;
        end
      end
      StXfer: begin
        s_axi_dma_trdy          = m_axi_trdy[r_grant_idx];
        m_axi_tvld[r_grant_idx] = s_axi_dma_tvld;
        m_axi_tlast             = w_last;
        if (w_beat && w_last) begin
          w_state_d = StArb;
        end
      end
      default: w_state_d = StArb;
    endcase
  end

  always_ff @(posedge clk_dma) begin
    if (srst) begin
      r_rr_ptr      <= '0;
      r_grant_idx   <= '0;
      r_len         <= '0;
      r_beat_cnt    <= '0;
      r_burst_done  <= 1'b0;
      r_burst_total <= '0;
    end else begin
      r_burst_done <= 1'b0;
      if (r_state == StArb) begin
        if (w_pick_found) begin
          r_grant_idx <= w_pick_idx;
          r_len       <= (burst_len == '0) ? LW'(1) : burst_len;
          r_beat_cnt  <= '0;
        end
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + LW'(1);
        if (w_last) begin
          r_rr_ptr      <= w_rr_next;
          r_burst_done  <= 1'b1;
          r_burst_total <= r_burst_total + 32'd1;
        end
      end
    end
  end

  assign m_axi_tdat  = s_axi_dma_tdat;
  assign grant_vld   = (r_state == StXfer);
  assign grant_idx   = r_grant_idx;
  assign burst_done  = r_burst_done;
  assign burst_total = r_burst_total;

endmodule

// File: tb/tb_dma_tx_burst_sched.sv
// Directed bench for dma_tx_burst_sched: arbitration order, burst length, stalls and reset.
module tb_dma_tx_burst_sched;
  localparam int N  = 8;
  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk_dma = 1'b0;
  logic          srst;
  logic [LW-1:0] burst_len;
  logic          s_axi_dma_tvld;
  logic          s_axi_dma_trdy;
  logic [DW-1:0] s_axi_dma_tdat;
  logic [N-1:0]  dst_req;
  logic [N-1:0]  m_axi_tvld;
  logic [N-1:0]  m_axi_trdy;
  logic [DW-1:0] m_axi_tdat;
  logic          m_axi_tlast;
  logic          grant_vld;
  logic [2:0]    grant_idx;
  logic          burst_done;
  logic [31:0]   burst_total;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_total = 0;

  always #5 clk_dma = ~clk_dma;

  dma_tx_burst_sched #(.N_DST(N), .DW(DW), .LW(LW)) dut (
    .clk_dma        (clk_dma),
    .srst           (srst),
    .burst_len      (burst_len),
    .s_axi_dma_tvld (s_axi_dma_tvld),
    .s_axi_dma_trdy (s_axi_dma_trdy),
    .s_axi_dma_tdat (s_axi_dma_tdat),
    .dst_req        (dst_req),
    .m_axi_tvld     (m_axi_tvld),
    .m_axi_trdy     (m_axi_trdy),
    .m_axi_tdat     (m_axi_tdat),
    .m_axi_tlast    (m_axi_tlast),
    .grant_vld      (grant_vld),
    .grant_idx      (grant_idx),
    .burst_done     (burst_done),
    .burst_total    (burst_total)
  );

  // Returns at the negedge with srst released and inputs idle.
  task automatic apply_reset();
    srst = 1'b1;
    dst_req = '0;
    s_axi_dma_tvld = 1'b1;
    m_axi_trdy = '1;
    repeat (2) @(posedge clk_dma);
    @(negedge clk_dma);
    srst = 1'b0;
    exp_total = 0;
  endtask

  // Observes one burst; starts and ends at a negedge. No comparisons here, only measurements.
  task automatic observe_burst(input bit stall, input int new_len,
                               output int wait_cyc, output int idx, output int beats,
                               output logic [N-1:0] mask, output logic done,
                               output logic gv_after, output logic arb_bad,
                               output int data_err, output logic timeout);
    logic [DW-1:0] base;
    logic          beat;
    logic          last;
    wait_cyc = 0; idx = -1; beats = 0; mask = '0; done = 1'b0; gv_after = 1'b1;
    arb_bad = 1'b0; data_err = 0; timeout = 1'b0; last = 1'b0;
    base = {32'hA5A5_0000, $urandom};
    s_axi_dma_tdat = base;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk_dma);
      if (grant_vld) break;
      if (s_axi_dma_trdy || (m_axi_tvld != '0) || m_axi_tlast) arb_bad = 1'b1;
      wait_cyc++;
    end
    if (!grant_vld) begin
      timeout = 1'b1;
      return;
    end
    idx = int'(grant_idx);
    for (int c = 0; c < 400; c++) begin
      mask |= m_axi_tvld;
      beat = s_axi_dma_tvld && m_axi_trdy[idx];
      if (beat) begin
        if (m_axi_tdat !== base + DW'(beats)) data_err++;
        beats++;
        last = m_axi_tlast;
      end
      @(posedge clk_dma);
      #1;
      if (beat) s_axi_dma_tdat = base + DW'(beats);
      if (beat && new_len != 0) burst_len = LW'(new_len);
      if (last) break;
      if (stall) begin
        s_axi_dma_tvld = ($urandom_range(0, 3) != 0);
        m_axi_trdy = N'($urandom);
      end
      @(negedge clk_dma);
    end
    s_axi_dma_tvld = 1'b1;
    m_axi_trdy = '1;
    if (!last) begin
      timeout = 1'b1;
      return;
    end
    @(negedge clk_dma);
    done = burst_done;
    gv_after = grant_vld;
    if (s_axi_dma_trdy || (m_axi_tvld != '0) || m_axi_tlast) arb_bad = 1'b1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    dst_req = '1;
    burst_len = 16'd4;
    s_axi_dma_tvld = 1'b1;
    m_axi_trdy = '1;
    s_axi_dma_tdat = '0;
    repeat (2) @(posedge clk_dma);
    @(negedge clk_dma);
    n_checks++; if (grant_vld !== 1'b0) $display("FAIL reset_grant_vld got %b want 0", grant_vld); else n_pass++;
    n_checks++; if (grant_idx !== 3'd0) $display("FAIL reset_grant_idx got %0d want 0", grant_idx); else n_pass++;
    n_checks++; if (m_axi_tvld !== 8'h00) $display("FAIL reset_m_tvld got %h want 00", m_axi_tvld); else n_pass++;
    n_checks++; if (s_axi_dma_trdy !== 1'b0) $display("FAIL reset_s_trdy got %b want 0", s_axi_dma_trdy); else n_pass++;
    n_checks++; if (m_axi_tlast !== 1'b0) $display("FAIL reset_tlast got %b want 0", m_axi_tlast); else n_pass++;
    n_checks++; if (burst_done !== 1'b0) $display("FAIL reset_done got %b want 0", burst_done); else n_pass++;
    n_checks++; if (burst_total !== 32'd0) $display("FAIL reset_total got %0d want 0", burst_total); else n_pass++;
    dst_req = '0;
    srst = 1'b0;
    exp_total = 0;
  endtask

  task automatic test_single_burst();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    dst_req = 8'h01;
    burst_len = 16'd4;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    dst_req = '0;
    exp_total++;
    n_checks++; if (to !== 1'b0) $display("FAIL t1_timeout got %b want 0", to); else n_pass++;
    n_checks++; if (w != 0) $display("FAIL t1_grant_latency got %0d want 0", w); else n_pass++;
    n_checks++; if (idx != 0) $display("FAIL t1_grant_idx got %0d want 0", idx); else n_pass++;
    n_checks++; if (beats != 4) $display("FAIL t1_beats_to_tlast got %0d want 4", beats); else n_pass++;
    n_checks++; if (mask !== 8'h01) $display("FAIL t1_tvld_mask got %h want 01", mask); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL t1_done got %b want 1", done); else n_pass++;
    n_checks++; if (gva !== 1'b0) $display("FAIL t1_grant_vld_after got %b want 0", gva); else n_pass++;
    n_checks++; if (derr != 0) $display("FAIL t1_data got %0d errors want 0", derr); else n_pass++;
    n_checks++; if (burst_total !== 32'(exp_total)) $display("FAIL t1_total got %0d want %0d", burst_total, exp_total); else n_pass++;
  endtask

  task automatic test_round_robin();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    apply_reset();
    dst_req = 8'hFF;
    burst_len = 16'd2;
    for (int k = 0; k < 9; k++) begin
      observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
      if (k == 8) dst_req = '0;
      exp_total++;
      n_checks++; if (idx != (k % 8) || to) $display("FAIL t2_grant_%0d got %0d want %0d", k, idx, k % 8); else n_pass++;
      n_checks++; if (beats != 2 || w != 0 || done !== 1'b1) $display("FAIL t2_burst_%0d got beats=%0d gap_extra=%0d done=%b want 2/0/1", k, beats, w, done); else n_pass++;
    end
    n_checks++; if (burst_total !== 32'(exp_total)) $display("FAIL t2_total got %0d want %0d", burst_total, exp_total); else n_pass++;
  endtask

  task automatic test_rr_skip();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    // rr_ptr is 1 here; granting 2 moves it to 3.
    dst_req = 8'h04;
    burst_len = 16'd2;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    exp_total++;
    n_checks++; if (idx != 2) $display("FAIL t3_setup_idx got %0d want 2", idx); else n_pass++;
    dst_req = 8'h84;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    exp_total++;
    n_checks++; if (idx != 7) $display("FAIL t3_first_idx got %0d want 7", idx); else n_pass++;
    n_checks++; if (mask !== 8'h80) $display("FAIL t3_first_mask got %h want 80", mask); else n_pass++;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    dst_req = '0;
    exp_total++;
    n_checks++; if (idx != 2) $display("FAIL t3_second_idx got %0d want 2", idx); else n_pass++;
    n_checks++; if (mask !== 8'h04) $display("FAIL t3_second_mask got %h want 04", mask); else n_pass++;
    n_checks++; if (burst_total !== 32'(exp_total)) $display("FAIL t3_total got %0d want %0d", burst_total, exp_total); else n_pass++;
  endtask

  task automatic test_len_edge();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    dst_req = 8'h01;
    burst_len = 16'd0;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    exp_total++;
    n_checks++; if (beats != 1 || to) $display("FAIL t4_len0_beats got %0d want 1", beats); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL t4_len0_done got %b want 1", done); else n_pass++;
    burst_len = 16'd3;
    observe_burst(1'b0, 9, w, idx, beats, mask, done, gva, ab, derr, to);
    dst_req = '0;
    burst_len = 16'd3;
    exp_total++;
    n_checks++; if (beats != 3 || to) $display("FAIL t4_len_latched got %0d want 3", beats); else n_pass++;
    n_checks++; if (burst_total !== 32'(exp_total)) $display("FAIL t4_total got %0d want %0d", burst_total, exp_total); else n_pass++;
  endtask

  task automatic test_stalls();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    dst_req = 8'h02;
    burst_len = 16'd16;
    observe_burst(1'b1, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    dst_req = '0;
    exp_total++;
    n_checks++; if (beats != 16 || to) $display("FAIL t5_beats got %0d want 16", beats); else n_pass++;
    n_checks++; if (derr != 0) $display("FAIL t5_data_order got %0d errors want 0", derr); else n_pass++;
    n_checks++; if (ab !== 1'b0) $display("FAIL t5_arb_quiet got %b want 0", ab); else n_pass++;
    n_checks++; if ((mask & ~8'h02) !== 8'h00) $display("FAIL t5_mask got %h want subset of 02", mask); else n_pass++;
    n_checks++; if (burst_total !== 32'(exp_total)) $display("FAIL t5_total got %0d want %0d", burst_total, exp_total); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int b = 0;
    logic hit = 1'b0;
    logic saw_done = 1'b0;
    // rr_ptr is 2 here, so destination 3 is granted.
    dst_req = 8'h08;
    burst_len = 16'd8;
    s_axi_dma_tvld = 1'b1;
    m_axi_trdy = '1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_dma);
      if (grant_vld) begin
        if (b == 4) begin
          srst = 1'b1;
          hit = 1'b1;
          break;
        end
        b++;
      end
    end
    n_checks++; if (hit !== 1'b1) $display("FAIL t6_reached_beat5 got %b want 1", hit); else n_pass++;
    @(negedge clk_dma);
    n_checks++; if (grant_vld !== 1'b0) $display("FAIL t6_grant_vld got %b want 0", grant_vld); else n_pass++;
    n_checks++; if (grant_idx !== 3'd0) $display("FAIL t6_grant_idx got %0d want 0", grant_idx); else n_pass++;
    n_checks++; if (m_axi_tvld !== 8'h00 || s_axi_dma_trdy !== 1'b0 || m_axi_tlast !== 1'b0)
      $display("FAIL t6_handshake got tvld=%h trdy=%b tlast=%b want 00/0/0", m_axi_tvld, s_axi_dma_trdy, m_axi_tlast); else n_pass++;
    n_checks++; if (burst_done !== 1'b0) $display("FAIL t6_done got %b want 0", burst_done); else n_pass++;
    srst = 1'b0;
    dst_req = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_dma);
      if (burst_done) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) $display("FAIL t6_no_done_pulse got %b want 0", saw_done); else n_pass++;
  endtask

  task automatic test_after_reset();
    int w, idx, beats, derr; logic [N-1:0] mask; logic done, gva, ab, to;
    dst_req = 8'hFF;
    burst_len = 16'd2;
    observe_burst(1'b0, 0, w, idx, beats, mask, done, gva, ab, derr, to);
    dst_req = '0;
    n_checks++; if (idx != 0 || to) $display("FAIL t7_rr_ptr_reset got %0d want 0", idx); else n_pass++;
    n_checks++; if (beats != 2) $display("FAIL t7_beats got %0d want 2", beats); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_rr_skip();
    test_len_edge();
    test_stalls();
    test_reset_mid_burst();
    test_after_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
